// File: rtl/mcpu2_core.sv
// mcpu2_core: parametrised multi-cycle CPU core with handshaked memories.
// Internal register file and ALU; FETCH/EXEC/MEM/WB/HALT sequencing.
module mcpu2_core #(
    parameter int WORD_SIZE    = 16,
    parameter int OPERAND_SIZE = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [WORD_SIZE-1:0]  imem_rdata,
    output logic                  dmem_re,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [WORD_SIZE-1:0]  dmem_wdata,
    input  logic                  dmem_ready,
    input  logic [WORD_SIZE-1:0]  dmem_rdata,
    output logic                  carry,
    output logic                  halted,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  retired
);

    localparam int OW   = OPERAND_SIZE;
    localparam int NREG = 1 << OW;

    localparam logic [WORD_SIZE-1:0]  LP_WS = WORD_SIZE[WORD_SIZE-1:0];
    localparam logic [ADDR_WIDTH-1:0] LP_A1 = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  LP_C1 = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_LSL   = 4'd4;
    localparam logic [3:0] OP_LSR   = 4'd5;
    localparam logic [3:0] OP_MOV   = 4'd6;
    localparam logic [3:0] OP_LOAD  = 4'd7;
    localparam logic [3:0] OP_STORE = 4'd8;
    localparam logic [3:0] OP_SHORT = 4'd9;
    localparam logic [3:0] OP_BNZ   = 4'd10;
    localparam logic [3:0] OP_BZ    = 4'd11;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [WORD_SIZE-1:0]  r_ir;
    logic [WORD_SIZE-1:0]  r_regs [NREG];
    logic [WORD_SIZE-1:0]  r_result;
    logic                  r_carry;
    logic                  r_halted;
    logic                  r_illegal;
    logic [CNT_WIDTH-1:0]  r_retired;

    logic [3:0]            w_op;
    logic [OW-1:0]         w_f1;
    logic [OW-1:0]         w_f2;
    logic [OW-1:0]         w_f3;
    logic [ADDR_WIDTH-1:0] w_imm;
    logic [WORD_SIZE-1:0]  w_short;
    logic [WORD_SIZE-1:0]  w_a;
    logic [WORD_SIZE-1:0]  w_b;
    logic [WORD_SIZE-1:0]  w_d;
    logic [WORD_SIZE:0]    w_sum;
    logic [WORD_SIZE-1:0]  w_alu;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic                  w_big;
    logic                  w_take;
    logic                  w_is_ill;
    logic                  w_is_halt;
    logic                  w_is_mem;
    logic                  w_is_br;

    assign w_op    = r_ir[WORD_SIZE-1 -: 4];
    assign w_f1    = r_ir[3*OW-1 -: OW];
    assign w_f2    = r_ir[2*OW-1 -: OW];
    assign w_f3    = r_ir[OW-1:0];
    assign w_imm   = r_ir[ADDR_WIDTH-1:0];
    assign w_short = {{(WORD_SIZE-2*OW){1'b0}}, r_ir[2*OW-1:0]};

    assign w_a     = r_regs[w_f2];
    assign w_b     = r_regs[w_f3];
    assign w_d     = r_regs[w_f1];
    assign w_sum   = {1'b0, w_a} + {1'b0, w_b};
    assign w_big   = (w_b >= LP_WS);

    assign w_pc_inc  = r_pc + LP_A1;
    assign w_take    = (w_op == OP_BNZ) ? (w_d != '0) : (w_d == '0);
    assign w_is_ill  = (w_op > OP_BZ) && (w_op != OP_HALT);
    assign w_is_halt = (w_op == OP_HALT);
    assign w_is_mem  = (w_op == OP_LOAD) || (w_op == OP_STORE);
    assign w_is_br   = (w_op == OP_BNZ) || (w_op == OP_BZ);

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_AND:   w_alu = w_a & w_b;
            OP_OR:    w_alu = w_a | w_b;
            OP_XOR:   w_alu = w_a ^ w_b;
            OP_ADD:   w_alu = w_sum[WORD_SIZE-1:0];
            OP_LSL:   w_alu = w_big ? '0 : (w_a << w_b);
            OP_LSR:   w_alu = w_big ? '0 : (w_a >> w_b);
            OP_MOV:   w_alu = w_a;
            OP_SHORT: w_alu = w_short;
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_ir      <= '0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_retired <= '0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    unique case (1'b1)
                        w_is_ill: begin
                            r_illegal <= 1'b1;
                            r_halted  <= 1'b1;
                            r_state   <= S_HALT;
                        end
                        w_is_halt: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        w_is_mem: r_state <= S_MEM;
                        w_is_br: begin
                            r_pc      <= w_take ? w_imm : w_pc_inc;
                            r_retired <= r_retired + LP_C1;
                            r_state   <= S_FETCH;
                        end
                        default: begin
                            r_result <= w_alu;
                            if (w_op == OP_ADD) r_carry <= w_sum[WORD_SIZE];
                            r_state  <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (w_op == OP_LOAD) r_result <= dmem_rdata;
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    if (w_op != OP_STORE) r_regs[w_f1] <= r_result;
                    r_pc      <= w_pc_inc;
                    r_retired <= r_retired + LP_C1;
                    r_state   <= S_FETCH;
                end
                S_HALT: ;
                default: r_state <= S_HALT;
            endcase
        end
    end

    // Requests are masked by reset so an in-flight access drops immediately.
    assign imem_req   = !reset && (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign dmem_re    = !reset && (r_state == S_MEM) && (w_op == OP_LOAD);
    assign dmem_we    = !reset && (r_state == S_MEM) && (w_op == OP_STORE);
    assign dmem_addr  = w_imm;
    assign dmem_wdata = w_d;

    assign carry   = r_carry;
    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule
